// File: rtl/xbar_pkg.sv
// Shared types and constants for the slave-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xbar_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   localparam int DEF_N_MASTERS = 2;
   localparam int DEF_AW        = 32;
   localparam int DEF_DW        = 32;

   // Width of a master index; never narrower than one bit.
   function automatic int grant_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/slave_port_arbiter_if.sv
// Bundle of master-side request/ack and slave-side request/ack signals.
// Latency: n/a (wires only).
// Backpressure: masters hold m_req until m_ack; arbiter holds s_req until s_ack.
interface slave_port_arbiter_if #(
   parameter int N_MASTERS = xbar_pkg::DEF_N_MASTERS,
   parameter int AW        = xbar_pkg::DEF_AW,
   parameter int DW        = xbar_pkg::DEF_DW
) ();
   import xbar_pkg::*;

   localparam int GW = grant_w(N_MASTERS);

   logic [N_MASTERS-1:0]    m_req;
   logic [N_MASTERS-1:0]    m_cmd;
   logic [N_MASTERS*AW-1:0] m_addr;
   logic [N_MASTERS*DW-1:0] m_wdata;
   logic [N_MASTERS-1:0]    m_ack;
   logic                    m_err;
   logic [DW-1:0]           m_rdata;
   logic [GW-1:0]           m_grant;
   logic                    s_req;
   logic                    s_cmd;
   logic [AW-1:0]           s_addr;
   logic [DW-1:0]           s_wdata;
   logic                    s_ack;
   logic [DW-1:0]           s_rdata;

   // Arbiter view: it is the slave of the masters and the master of the slave port.
   modport slave (
      input  m_req, m_cmd, m_addr, m_wdata, s_ack, s_rdata,
      output m_ack, m_err, m_rdata, m_grant, s_req, s_cmd, s_addr, s_wdata
   );

   // Environment view: requesting masters plus the downstream slave.
   modport master (
      output m_req, m_cmd, m_addr, m_wdata, s_ack, s_rdata,
      input  m_ack, m_err, m_rdata, m_grant, s_req, s_cmd, s_addr, s_wdata
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin search: first set request bit at or above ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; any_o low when no request is pending.
module rr_pick import xbar_pkg::*; #(
   parameter int N  = DEF_N_MASTERS,
   parameter int GW = grant_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [GW-1:0] ptr_i,
   output logic [GW-1:0] win_o,
   output logic          any_o
);

   // Pick the requester with the smallest circular distance from the pointer.
   always_comb begin
      int best_d;
      int d;
      best_d = N;
      d      = 0;
      win_o  = '0;
      any_o  = 1'b0;
      for (int i = 0; i < N; i++) begin
         d = (i + N - int'(ptr_i)) % N;
         if (req_i[i] && (d < best_d)) begin
            best_d = d;
            win_o  = GW'(i);
            any_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/slave_port_arbiter.sv
// Round-robin arbiter sharing one slave port among N_MASTERS; optional WAIT timeout via ARB_TIMEOUT_EN.
// Latency: grant 1 cycle after request, m_ack 1 cycle after s_ack (3-cycle minimum per transaction).
// Backpressure: s_req held until s_ack (or timeout); masters hold m_req until their m_ack.
module slave_port_arbiter import xbar_pkg::*; #(
   parameter int N_MASTERS   = DEF_N_MASTERS,
   parameter int AW          = DEF_AW,
   parameter int DW          = DEF_DW,
   parameter int TIMEOUT_CYC = 255
) (
   input logic           clk,
   input logic           rst_n,
   slave_port_arbiter_if.slave bus
);

   localparam int GW = grant_w(N_MASTERS);

   // Reject configurations the datapath is not built for.
   if (N_MASTERS < 2 || N_MASTERS > 8) begin : g_bad_masters
      $error("slave_port_arbiter: N_MASTERS must be 2..8");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("slave_port_arbiter: TIMEOUT_CYC must be at least 1");
   end

   arb_state_t    state_q, state_d;
   logic [GW-1:0] grant_q;
   logic [GW-1:0] rr_ptr_q;
   logic          cmd_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic [GW-1:0] pick_win;
   logic          pick_any;
   logic          tmo_hit;

   rr_pick #(.N(N_MASTERS), .GW(GW)) u_pick (
      .req_i (bus.m_req),
      .ptr_i (rr_ptr_q),
      .win_o (pick_win),
      .any_o (pick_any)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q;
   logic          err_q;

   assign tmo_hit = (state_q == ST_WAIT) && (cnt_q == CW'(TIMEOUT_CYC - 1));

   // Count cycles spent in WAIT and remember whether the transaction was aborted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (state_q == ST_WAIT) begin
         cnt_q <= cnt_q + 1'b1;
         if (!bus.s_ack && tmo_hit) begin
            err_q <= 1'b1;
         end
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // State register; reset drops any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: arbitrate in IDLE, wait for the slave, then one ack cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pick_any) state_d = ST_WAIT;
         ST_WAIT: if (bus.s_ack || tmo_hit) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Latch the winner's request, capture read data, advance the round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q  <= '0;
         rr_ptr_q <= '0;
         cmd_q    <= CMD_READ;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  grant_q <= pick_win;
                  cmd_q   <= bus.m_cmd[pick_win] ? CMD_WRITE : CMD_READ;
                  addr_q  <= bus.m_addr[pick_win*AW +: AW];
                  wdata_q <= bus.m_wdata[pick_win*DW +: DW];
               end
            end
            ST_WAIT: begin
               if (bus.s_ack) begin
                  if (cmd_q == CMD_READ) rdata_q <= bus.s_rdata;
               end else if (tmo_hit) begin
                  rdata_q <= '0;
               end
            end
            ST_RESP: begin
               rr_ptr_q <= (int'(grant_q) == N_MASTERS - 1) ? '0 : grant_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state and latched request.
   always_comb begin
      bus.s_req   = (state_q == ST_WAIT);
      bus.s_cmd   = cmd_q;
      bus.s_addr  = addr_q;
      bus.s_wdata = wdata_q;
      bus.m_grant = grant_q;
      bus.m_rdata = rdata_q;
      bus.m_ack   = '0;
      if (state_q == ST_RESP) bus.m_ack[grant_q] = 1'b1;
`ifdef ARB_TIMEOUT_EN
      bus.m_err   = (state_q == ST_RESP) && err_q;
`else
      bus.m_err   = 1'b0;
`endif
   end

endmodule
